// File: rtl/gray_tracker_if.sv
// Bus between the upstream Gray counter stage and the gray_tracker consumer:
// sampled inputs (Clr, Gray, Overflow) and the registered tracking results.
interface gray_tracker_if #(
  parameter int W    = 3,
  parameter int LAPW = 8,
  parameter int ERRW = 4
);
  logic            Clr;
  logic [W-1:0]    Gray;
  logic            Overflow;
  logic [W-1:0]    Bin;
  logic            Step;
  logic            Back;
  logic            Error;
  logic [LAPW-1:0] Laps;
  logic [ERRW-1:0] ErrCnt;
  logic            Locked;

  modport master (
    output Clr, Gray, Overflow,
    input  Bin, Step, Back, Error, Laps, ErrCnt, Locked
  );

  modport slave (
    input  Clr, Gray, Overflow,
    output Bin, Step, Back, Error, Laps, ErrCnt, Locked
  );
endinterface

// File: rtl/gray_tracker.sv
// Tracks a Gray-coded position counter: converts to binary, classifies each
// transition, counts net forward laps and saturating errors, resyncs on zero.
module gray_tracker #(
  parameter int W    = 3,
  parameter int LAPW = 8,
  parameter int ERRW = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  gray_tracker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOCKED, FAULT} state_t;

  localparam logic [W-1:0]    BIN_MAX = '1;
  localparam logic [W-1:0]    BIN_ONE = W'(1);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (v == ERR_MAX) ? v : v + ERRW'(1);
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic            step_q, step_d;
  logic            back_q, back_d;
  logic            error_q, error_d;
  logic [LAPW-1:0] laps_q, laps_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            locked_q, locked_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0] nb;
  logic [W-1:0] delta;
  logic         ovf_rise;
  logic         ovf_fall;
  logic         fwd_wrap;
  logic         bad_evt;

  assign nb       = gray2bin(bus.Gray);
  assign delta    = nb - bin_q;
  assign ovf_rise = bus.Overflow & ~ovf_q;
  assign ovf_fall = ~bus.Overflow & ovf_q;
  assign fwd_wrap = (bin_q == BIN_MAX) && (nb == '0);

  always_comb begin
    state_d   = state_q;
    bin_d     = nb;
    step_d    = 1'b0;
    back_d    = 1'b0;
    error_d   = 1'b0;
    laps_d    = laps_q;
    err_cnt_d = err_cnt_q;
    ovf_d     = bus.Overflow;
    bad_evt   = 1'b0;

    if (bus.Clr) begin
      laps_d    = '0;
      err_cnt_d = '0;
      state_d   = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = LOCKED;
        LOCKED: begin
          // Overflow dropping onto code zero means upstream was reset: not a jump.
          if (ovf_fall && nb == '0) begin
            state_d = LOCKED;
          end else if (ovf_rise && !fwd_wrap) begin
            bad_evt = 1'b1;
          end else if (delta == '0) begin
            state_d = LOCKED;
          end else if (delta == BIN_ONE) begin
            step_d = 1'b1;
            if (bin_q == BIN_MAX) laps_d = laps_q + LAPW'(1);
          end else if (delta == BIN_MAX) begin
            back_d = 1'b1;
            if (bin_q == '0) laps_d = laps_q - LAPW'(1);
          end else begin
            bad_evt = 1'b1;
          end
          if (bad_evt) begin
            error_d   = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = FAULT;
          end
        end
        FAULT: if (nb == '0) state_d = LOCKED;
        default: state_d = IDLE;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // Sample stage: every output is a flop loaded from the same edge's inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      step_q    <= 1'b0;
      back_q    <= 1'b0;
      error_q   <= 1'b0;
      laps_q    <= '0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      step_q    <= step_d;
      back_q    <= back_d;
      error_q   <= error_d;
      laps_q    <= laps_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.Bin    = bin_q;
  assign bus.Step   = step_q;
  assign bus.Back   = back_q;
  assign bus.Error  = error_q;
  assign bus.Laps   = laps_q;
  assign bus.ErrCnt = err_cnt_q;
  assign bus.Locked = locked_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Scenario bench for gray_tracker: each task queues the expected output word
// when it drives a sample and pops it after the edge to compare.
module tb_gray_tracker;

  typedef struct packed {
    logic [2:0] bin;
    logic       step;
    logic       back;
    logic       err;
    logic [7:0] laps;
    logic [3:0] ec;
    logic       lock;
  } out_t;

  typedef struct packed {
    logic [2:0] g;
    logic       o;
    logic       c;
    out_t       x;
  } vec_t;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];

  gray_tracker_if #(.W(3), .LAPW(8), .ERRW(4)) bus ();

  gray_tracker #(.W(3), .LAPW(8), .ERRW(4)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(logic [2:0] b, logic s, logic bk, logic e,
                              logic [7:0] l, logic [3:0] ec, logic lk);
    out_t r;
    r.bin = b; r.step = s; r.back = bk; r.err = e;
    r.laps = l; r.ec = ec; r.lock = lk;
    return r;
  endfunction

  function automatic vec_t vec(logic [2:0] g, logic o, logic c, out_t x);
    vec_t r;
    r.g = g; r.o = o; r.c = c; r.x = x;
    return r;
  endfunction

  function automatic logic [2:0] b2g(int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic out_t sample();
    return mk(bus.Bin, bus.Step, bus.Back, bus.Error, bus.Laps, bus.ErrCnt, bus.Locked);
  endfunction

  task automatic step_in(input logic [2:0] g, input logic o, input logic c);
    bus.Gray = g; bus.Overflow = o; bus.Clr = c;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    out_t obs;
    Reset = 1'b1; bus.Gray = 3'b000; bus.Overflow = 1'b0; bus.Clr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    obs = sample();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, out_t'(0));
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_forward();
    out_t obs, e;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(mk(3'(i % 8), i > 0, 1'b0, 1'b0, (i == 8) ? 8'd1 : 8'd0, 4'd0, 1'b1));
      step_in(b2g(i % 8), i == 8, 1'b0);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL fwd[%0d] got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_backward();
    vec_t v[$];
    out_t obs, e;
    v.push_back(vec(3'b001, 1'b1, 1'b1, mk(3'd1, 0, 0, 0, 8'd0,   4'd0, 0)));
    v.push_back(vec(3'b001, 1'b1, 1'b0, mk(3'd1, 0, 0, 0, 8'd0,   4'd0, 1)));
    v.push_back(vec(3'b000, 1'b1, 1'b0, mk(3'd0, 0, 1, 0, 8'd0,   4'd0, 1)));
    v.push_back(vec(3'b100, 1'b1, 1'b0, mk(3'd7, 0, 1, 0, 8'd255, 4'd0, 1)));
    foreach (v[i]) begin
      exp_q.push_back(v[i].x);
      step_in(v[i].g, v[i].o, v[i].c);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL back[%0d] got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_illegal_jump();
    vec_t v[$];
    out_t obs, e;
    v.push_back(vec(3'b000, 1'b1, 1'b0, mk(3'd0, 1, 0, 0, 8'd0, 4'd0, 1)));
    v.push_back(vec(3'b001, 1'b1, 1'b0, mk(3'd1, 1, 0, 0, 8'd0, 4'd0, 1)));
    v.push_back(vec(3'b110, 1'b1, 1'b0, mk(3'd4, 0, 0, 1, 8'd0, 4'd1, 0)));
    v.push_back(vec(3'b111, 1'b1, 1'b0, mk(3'd5, 0, 0, 0, 8'd0, 4'd1, 0)));
    v.push_back(vec(3'b101, 1'b1, 1'b0, mk(3'd6, 0, 0, 0, 8'd0, 4'd1, 0)));
    v.push_back(vec(3'b000, 1'b1, 1'b0, mk(3'd0, 0, 0, 0, 8'd0, 4'd1, 1)));
    v.push_back(vec(3'b001, 1'b1, 1'b0, mk(3'd1, 1, 0, 0, 8'd0, 4'd1, 1)));
    foreach (v[i]) begin
      exp_q.push_back(v[i].x);
      step_in(v[i].g, v[i].o, v[i].c);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL jump[%0d] got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_overflow();
    vec_t v[$];
    out_t obs, e;
    for (int b = 2; b <= 6; b++)
      v.push_back(vec(b2g(b), 1'b1, 1'b0, mk(3'(b), 1, 0, 0, 8'd0, 4'd1, 1)));
    // Overflow falls with code jumping 6 -> 0: upstream reset, no error.
    v.push_back(vec(3'b000, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 8'd0, 4'd1, 1)));
    v.push_back(vec(3'b001, 1'b0, 1'b0, mk(3'd1, 1, 0, 0, 8'd0, 4'd1, 1)));
    v.push_back(vec(3'b011, 1'b0, 1'b0, mk(3'd2, 1, 0, 0, 8'd0, 4'd1, 1)));
    v.push_back(vec(3'b010, 1'b0, 1'b0, mk(3'd3, 1, 0, 0, 8'd0, 4'd1, 1)));
    // Overflow rises on an ordinary 3 -> 4 step: error.
    v.push_back(vec(3'b110, 1'b1, 1'b0, mk(3'd4, 0, 0, 1, 8'd0, 4'd2, 0)));
    v.push_back(vec(3'b000, 1'b1, 1'b0, mk(3'd0, 0, 0, 0, 8'd0, 4'd2, 1)));
    foreach (v[i]) begin
      exp_q.push_back(v[i].x);
      step_in(v[i].g, v[i].o, v[i].c);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ovf[%0d] got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_err_saturation();
    out_t obs, e;
    logic [3:0] ec = 4'd2;
    for (int i = 0; i < 17; i++) begin
      ec = (ec == 4'd15) ? ec : ec + 4'd1;
      exp_q.push_back(mk(3'd4, 0, 0, 1, 8'd0, ec, 0));
      step_in(3'b110, 1'b1, 1'b0);
      exp_q.push_back(mk(3'd0, 0, 0, 0, 8'd0, ec, 1));
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sat_err[%0d] got=%h exp=%h", i, obs, e); end
      step_in(3'b000, 1'b1, 1'b0);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sat_sync[%0d] got=%h exp=%h", i, obs, e); end
    end
    checks++;
    if (bus.ErrCnt !== 4'd15) begin
      errors++; $display("FAIL sat_final got=%0d exp=15", bus.ErrCnt);
    end
  endtask

  task automatic test_async_reset();
    out_t obs, e;
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    obs = sample(); checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs, out_t'(0)); end
    bus.Gray = 3'b000; bus.Overflow = 1'b0; bus.Clr = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    exp_q.push_back(mk(3'd0, 0, 0, 0, 8'd0, 4'd0, 1));
    step_in(3'b000, 1'b0, 1'b0);
    obs = sample(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL restart got=%h exp=%h", obs, e); end
  endtask

  task automatic test_clear();
    vec_t v[$];
    out_t obs, e;
    for (int i = 1; i <= 24; i++)
      v.push_back(vec(b2g(i % 8), 1'b0, 1'b0, mk(3'(i % 8), 1, 0, 0, 8'(i / 8), 4'd0, 1)));
    v.push_back(vec(3'b001, 1'b0, 1'b1, mk(3'd1, 0, 0, 0, 8'd0, 4'd0, 0)));
    v.push_back(vec(3'b001, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 8'd0, 4'd0, 1)));
    // Clr overrides an illegal 1 -> 6 jump.
    v.push_back(vec(3'b101, 1'b0, 1'b1, mk(3'd6, 0, 0, 0, 8'd0, 4'd0, 0)));
    v.push_back(vec(3'b101, 1'b0, 1'b0, mk(3'd6, 0, 0, 0, 8'd0, 4'd0, 1)));
    foreach (v[i]) begin
      exp_q.push_back(v[i].x);
      step_in(v[i].g, v[i].o, v[i].c);
      obs = sample(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL clr[%0d] got=%h exp=%h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backward();
    test_illegal_jump();
    test_overflow();
    test_err_saturation();
    test_async_reset();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
